// File: rtl/idt_pkg.sv
// Shared definitions for the ICS307 serial programming controller:
// word field layout, FSM state encoding and the default boot word.
package idt_pkg;

    localparam int IDT_WORD_W  = 24;
    localparam int IDT_R_W     = 7;
    localparam int IDT_R_LSB   = 0;
    localparam int IDT_V_W     = 9;
    localparam int IDT_V_LSB   = 7;
    localparam int IDT_S_W     = 3;
    localparam int IDT_S_LSB   = 16;
    localparam int IDT_F_W     = 2;
    localparam int IDT_F_LSB   = 19;
    localparam int IDT_TTL_W   = 1;
    localparam int IDT_TTL_LSB = 21;
    localparam int IDT_C_W     = 2;
    localparam int IDT_C_LSB   = 22;
    localparam int IDT_BIT_W   = 5;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_STB_SETUP,
        ST_STROBE,
        ST_LOCK,
        ST_DONE
    } idt_state_e;

    function automatic logic [IDT_WORD_W-1:0] idt_word(
        input logic [IDT_C_W-1:0]   c,
        input logic [IDT_TTL_W-1:0] ttl,
        input logic [IDT_F_W-1:0]   f,
        input logic [IDT_S_W-1:0]   s,
        input logic [IDT_V_W-1:0]   v,
        input logic [IDT_R_W-1:0]   r
    );
        logic [IDT_WORD_W-1:0] w;
        w = '0;
        w[IDT_C_LSB   +: IDT_C_W]   = c;
        w[IDT_TTL_LSB +: IDT_TTL_W] = ttl;
        w[IDT_F_LSB   +: IDT_F_W]   = f;
        w[IDT_S_LSB   +: IDT_S_W]   = s;
        w[IDT_V_LSB   +: IDT_V_W]   = v;
        w[IDT_R_LSB   +: IDT_R_W]   = r;
        return w;
    endfunction

    // 148.5 MHz from a 100 MHz reference: C=00 TTL=1 F=10 S=001 V=41 R=31.
    localparam logic [IDT_WORD_W-1:0] IDT_BOOT_WORD =
        idt_word(2'b00, 1'b1, 2'b10, 3'b001, 9'd41, 7'd31);

endpackage

// File: rtl/idt_cfg_ctrl.sv
// ICS307 programming controller: optional boot load, req/ack reprogramming,
// MSB-first serial shift, load strobe and a PLL lock wait ending in done.
module idt_cfg_ctrl
    import idt_pkg::*;
#(
    parameter int unsigned           CLK_DIV     = 2,
    parameter int unsigned           LOCK_CYCLES = 1000,
    parameter bit                    BOOT_EN     = 1'b1,
    parameter logic [IDT_WORD_W-1:0] BOOT_WORD   = IDT_BOOT_WORD
) (
    input  logic                  clk,
    input  logic                  reset_,
    input  logic                  cfg_req,
    input  logic [IDT_WORD_W-1:0] cfg_word,
    output logic                  cfg_ack,
    output logic                  busy,
    output logic                  done,
    output logic                  idt_sclk,
    output logic                  idt_data,
    output logic                  idt_strobe
);

    localparam int unsigned CNT_MAX = (2 * CLK_DIV > LOCK_CYCLES) ? 2 * CLK_DIV : LOCK_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] HALF_LOAD = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] STB_LOAD  = CW'(2 * CLK_DIV - 1);
    localparam logic [CW-1:0] LOCK_LOAD = (LOCK_CYCLES == 0) ? '0 : CW'(LOCK_CYCLES - 1);

    idt_state_e            state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [IDT_BIT_W-1:0]  bit_idx_q, bit_idx_d;
    logic [IDT_WORD_W-1:0] shift_q, shift_d;
    logic                  boot_pend_q, boot_pend_d;
    logic                  accept_req;

    logic sclk_q, sclk_d;
    logic data_q, data_d;
    logic strobe_q, strobe_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic ack_q, ack_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its inputs, independent of block order.
    always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            boot_pend_q <= BOOT_EN;
            sclk_q      <= 1'b0;
            data_q      <= 1'b0;
            strobe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            boot_pend_q <= boot_pend_d;
            sclk_q      <= sclk_d;
            data_q      <= data_d;
            strobe_q    <= strobe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            ack_q       <= ack_d;
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        boot_pend_d = boot_pend_q;
        accept_req  = 1'b0;

        unique case (state_q)
            // DONE accepts like IDLE so a waiting requester is served without a gap.
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (boot_pend_q) begin
                    boot_pend_d = 1'b0;
                    shift_d     = BOOT_WORD;
                    bit_idx_d   = IDT_BIT_W'(IDT_WORD_W - 1);
                    cnt_d       = HALF_LOAD;
                    state_d     = ST_SETUP;
                end else if (cfg_req) begin
                    accept_req  = 1'b1;
                    shift_d     = cfg_word;
                    bit_idx_d   = IDT_BIT_W'(IDT_WORD_W - 1);
                    cnt_d       = HALF_LOAD;
                    state_d     = ST_SETUP;
                end
            end

            ST_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = HALF_LOAD;
                    state_d = ST_HIGH;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_HIGH: begin
                if (cnt_q == '0) begin
                    cnt_d = HALF_LOAD;
                    if (bit_idx_q == '0) begin
                        state_d = ST_STB_SETUP;
                    end else begin
                        bit_idx_d = bit_idx_q - 1'b1;
                        shift_d   = {shift_q[IDT_WORD_W-2:0], 1'b0};
                        state_d   = ST_SETUP;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STB_SETUP: begin
                if (cnt_q == '0) begin
                    cnt_d   = STB_LOAD;
                    state_d = ST_STROBE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_STROBE: begin
                if (cnt_q == '0) begin
                    cnt_d   = LOCK_LOAD;
                    state_d = (LOCK_CYCLES == 0) ? ST_DONE : ST_LOCK;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            ST_LOCK: begin
                if (cnt_q == '0) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are decoded from the next state and registered, so every pad
    // comes straight from a flop and lines up with the state it belongs to.
    always_comb begin
        sclk_d   = (state_d == ST_HIGH);
        data_d   = ((state_d == ST_SETUP) || (state_d == ST_HIGH)) && shift_d[IDT_WORD_W-1];
        strobe_d = (state_d == ST_STROBE);
        busy_d   = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_STB_SETUP)
                || (state_d == ST_STROBE) || (state_d == ST_LOCK);
        done_d   = (state_d == ST_DONE);
        ack_d    = accept_req;
    end

    assign cfg_ack    = ack_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign idt_sclk   = sclk_q;
    assign idt_data   = data_q;
    assign idt_strobe = strobe_q;

endmodule

// File: tb/tb_idt_cfg_ctrl.sv
// Bench for idt_cfg_ctrl: a boot-enabled instance (T=2, LOCK=10) and a
// request-only instance (T=1, LOCK=0); serial words checked against a scoreboard.
module tb_idt_cfg_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst_n;
    logic        req0, req1;
    logic [23:0] word0, word1;
    logic        ack0, busy0, done0, sclk0, data0, stb0;
    logic        ack1, busy1, done1, sclk1, data1, stb1;

    idt_cfg_ctrl #(.CLK_DIV(2), .LOCK_CYCLES(10), .BOOT_EN(1'b1), .BOOT_WORD(24'h31149F)) dut (
        .clk(clk), .reset_(rst_n), .cfg_req(req0), .cfg_word(word0),
        .cfg_ack(ack0), .busy(busy0), .done(done0),
        .idt_sclk(sclk0), .idt_data(data0), .idt_strobe(stb0)
    );

    idt_cfg_ctrl #(.CLK_DIV(1), .LOCK_CYCLES(0), .BOOT_EN(1'b0), .BOOT_WORD(24'h31149F)) dut_e (
        .clk(clk), .reset_(rst_n), .cfg_req(req1), .cfg_word(word1),
        .cfg_ack(ack1), .busy(busy1), .done(done1),
        .idt_sclk(sclk1), .idt_data(data1), .idt_strobe(stb1)
    );

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];
    logic [23:0] next_words[$];
    logic [23:0] boot_w = 24'h31149F;

    // Observation mux: sel picks which instance observe() watches and drives.
    bit   sel = 1'b0;
    logic m_ack, m_busy, m_done, m_sclk, m_data, m_stb;
    assign m_ack  = sel ? ack1  : ack0;
    assign m_busy = sel ? busy1 : busy0;
    assign m_done = sel ? done1 : done0;
    assign m_sclk = sel ? sclk1 : sclk0;
    assign m_data = sel ? data1 : data0;
    assign m_stb  = sel ? stb1  : stb0;

    int o_a, o_ack_cyc, o_acks, o_rises, o_first_rise, o_last_rise, o_last_fall;
    int o_stb_start, o_stb_len, o_done, o_busy_bad;
    logic        o_done_busy;
    logic [23:0] o_word;

    task automatic drive_word(input logic [23:0] w);
        if (sel) word1 = w; else word0 = w;
    endtask

    task automatic drop_req();
        if (sel) req1 = 1'b0; else req0 = 1'b0;
    endtask

    // Follows one sequence from busy rising to done, then scores the captured word.
    task automatic observe(input string tag);
        bit          started = 1'b0;
        bit          prev    = 1'b0;
        int          n       = 0;
        logic [23:0] exp_w;
        o_a = -1; o_ack_cyc = -1; o_acks = 0; o_rises = 0; o_first_rise = -1;
        o_last_rise = -1; o_last_fall = -1; o_stb_start = -1; o_stb_len = 0;
        o_done = -1; o_busy_bad = 0; o_done_busy = 1'b0; o_word = '0;
        while (o_done < 0 && n < 400) begin
            @(negedge clk);
            n++;
            if (m_ack) begin
                o_acks++;
                o_ack_cyc = cyc;
                if (next_words.size() > 0) drive_word(next_words.pop_front());
                else drop_req();
            end
            if (!started && m_busy) begin
                started = 1'b1;
                o_a     = cyc;
            end
            if (started) begin
                if (m_sclk && !prev) begin
                    o_rises++;
                    o_word = {o_word[22:0], m_data};
                    if (o_first_rise < 0) o_first_rise = cyc;
                    o_last_rise = cyc;
                end
                if (!m_sclk && prev) o_last_fall = cyc;
                prev = m_sclk;
                if (m_stb) begin
                    if (o_stb_len == 0) o_stb_start = cyc;
                    o_stb_len++;
                end
                if (m_done) begin
                    o_done      = cyc;
                    o_done_busy = m_busy;
                end else if (!m_busy) begin
                    o_busy_bad++;
                end
            end
        end
        checks++;
        if (o_done < 0) begin
            failures++;
            $display("FAIL %s_done_timeout: no done within %0d cycles", tag, n);
        end else begin
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL %s_word: captured %06h, scoreboard empty", tag, o_word);
            end else begin
                exp_w = exp_q.pop_front();
                if (o_word !== exp_w) begin
                    failures++;
                    $display("FAIL %s_word: captured %06h, expected %06h", tag, o_word, exp_w);
                end
            end
        end
    endtask

    task automatic cmp(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({ack0, busy0, done0, sclk0, data0, stb0} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs0: got %b, expected 000000", {ack0, busy0, done0, sclk0, data0, stb0});
        end
        checks++;
        if ({ack1, busy1, done1, sclk1, data1, stb1} !== 6'b0) begin
            failures++;
            $display("FAIL reset_outputs1: got %b, expected 000000", {ack1, busy1, done1, sclk1, data1, stb1});
        end
    endtask

    task automatic test_boot();
        int rel;
        sel = 1'b0;
        exp_q.push_back(boot_w);
        @(negedge clk);
        rst_n = 1'b1;
        rel   = cyc;
        observe("boot");
        cmp("boot_start", o_a, rel + 1);
        cmp("boot_rises", o_rises, 24);
        cmp("boot_first_rise", o_first_rise, o_a + 2);
        cmp("boot_last_fall", o_last_fall, o_a + 96);
        cmp("boot_stb_start", o_stb_start, o_a + 98);
        cmp("boot_stb_len", o_stb_len, 4);
        cmp("boot_done", o_done, o_a + 112);
        cmp("boot_no_ack", o_acks, 0);
        cmp("boot_busy_gap", o_busy_bad, 0);
        cmp("boot_busy_at_done", int'(o_done_busy), 0);
    endtask

    task automatic test_request();
        int req_cyc;
        sel = 1'b0;
        @(negedge clk);
        req_cyc = cyc;
        req0    = 1'b1;
        word0   = 24'hA5A5A5;
        exp_q.push_back(24'hA5A5A5);
        observe("req");
        cmp("req_ack_cycle", o_ack_cyc, req_cyc + 1);
        cmp("req_ack_count", o_acks, 1);
        cmp("req_start", o_a, o_ack_cyc);
        cmp("req_busy_gap", o_busy_bad, 0);
        cmp("req_done", o_done, o_a + 112);
        cmp("req_busy_at_done", int'(o_done_busy), 0);
    endtask

    task automatic test_req_during_boot();
        int d;
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        exp_q.push_back(boot_w);
        rst_n = 1'b1;
        fork
            observe("rdb_boot");
            begin
                repeat (5) @(negedge clk);
                req0  = 1'b1;
                word0 = 24'h123456;
                exp_q.push_back(24'h123456);
            end
        join
        d = o_done;
        cmp("rdb_no_ack_in_boot", o_acks, 0);
        observe("rdb_req");
        cmp("rdb_ack_after_done", o_ack_cyc, d + 1);
        cmp("rdb_ack_count", o_acks, 1);
    endtask

    task automatic test_back_to_back();
        int d;
        sel = 1'b0;
        @(negedge clk);
        req0  = 1'b1;
        word0 = 24'h000001;
        exp_q.push_back(24'h000001);
        exp_q.push_back(24'hFFFFFF);
        next_words.push_back(24'hFFFFFF);
        observe("b2b_first");
        d = o_done;
        observe("b2b_second");
        cmp("b2b_ack_after_done", o_ack_cyc, d + 1);
        cmp("b2b_second_ones", $countones(o_word), 24);
    endtask

    task automatic test_reset_mid_shift();
        int rises = 0;
        int stb_seen = 0;
        int rel;
        bit prev = 1'b0;
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (stb0) stb_seen++;
            if (sclk0 && !prev) rises++;
            if (!sclk0 && prev && rises == 13) break;
            prev = sclk0;
        end
        cmp("mid_rises_before", rises, 13);
        cmp("mid_data_bit10", int'(data0), int'(boot_w[10]));
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({sclk0, data0, stb0, busy0} !== 4'b0) begin
            failures++;
            $display("FAIL mid_async_drop: got %b, expected 0000", {sclk0, data0, stb0, busy0});
        end
        cmp("mid_no_strobe", stb_seen, 0);
        repeat (2) @(negedge clk);
        exp_q.push_back(boot_w);
        rst_n = 1'b1;
        rel   = cyc;
        observe("mid_reboot");
        cmp("mid_reboot_start", o_a, rel + 1);
        cmp("mid_reboot_rises", o_rises, 24);
        cmp("mid_reboot_stb_len", o_stb_len, 4);
    endtask

    task automatic test_edge_params();
        sel = 1'b1;
        @(negedge clk);
        cmp("edge_no_boot", int'(busy1), 0);
        req1  = 1'b1;
        word1 = 24'h5A3C96;
        exp_q.push_back(24'h5A3C96);
        observe("edge");
        cmp("edge_ack_at_start", o_ack_cyc, o_a);
        cmp("edge_rises", o_rises, 24);
        cmp("edge_first_rise", o_first_rise, o_a + 1);
        cmp("edge_sclk_period", o_last_rise - o_first_rise, 46);
        cmp("edge_last_fall", o_last_fall, o_a + 48);
        cmp("edge_stb_start", o_stb_start, o_a + 49);
        cmp("edge_stb_len", o_stb_len, 2);
        cmp("edge_done", o_done, o_a + 51);
    endtask

    initial begin
        rst_n = 1'b0;
        req0  = 1'b0;
        req1  = 1'b0;
        word0 = '0;
        word1 = '0;
        test_reset();
        test_boot();
        test_request();
        test_req_during_boot();
        test_back_to_back();
        test_reset_mid_shift();
        test_edge_params();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
